// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-and-add multiplier: retires RADIX_BITS multiplier bits per clock,
// signed or unsigned operands, full 2*WIDTH product, start/busy/done handshake.
module seq_mul_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned N  = WIDTH / RADIX_BITS;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state, stateNext;
  logic [PW-1:0]   mcand, mcandNext;
  logic [WIDTH-1:0] mplier, mplierNext;
  logic [PW-1:0]   acc, accNext;
  logic [CW-1:0]   count, countNext;
  logic            negate, negateNext;
  logic            busyNext, doneNext;
  logic [PW-1:0]   resultNext;
  logic [WIDTH-1:0] aMag, bMag;
  logic [PW-1:0]   partial, sum;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    aMag = (iSigned && iA[WIDTH-1]) ? (WIDTH'(0) - iA) : iA;
    bMag = (iSigned && iB[WIDTH-1]) ? (WIDTH'(0) - iB) : iB;
  end

  // Partial product of the shifted multiplicand and the low RADIX_BITS of the multiplier.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < RADIX_BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
    sum = acc + partial;
  end

  always_comb begin
    stateNext  = state;
    mcandNext  = mcand;
    mplierNext = mplier;
    accNext    = acc;
    countNext  = count;
    negateNext = negate;
    resultNext = oResult;
    busyNext   = 1'b0;
    doneNext   = 1'b0;
    case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (iStart) begin
          mcandNext  = PW'(aMag);
          mplierNext = bMag;
          accNext    = '0;
          countNext  = CW'(N);
          negateNext = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          stateNext  = RUN;
          busyNext   = 1'b1;
        end
      end
      RUN: begin
        accNext    = sum;
        mcandNext  = mcand << RADIX_BITS;
        mplierNext = mplier >> RADIX_BITS;
        countNext  = count - CW'(1);
        busyNext   = 1'b1;
        // Last digit: sign fix-up happens in the same edge that publishes the product.
        if (count == CW'(1)) begin
          stateNext  = DONE;
          busyNext   = 1'b0;
          doneNext   = 1'b1;
          resultNext = negate ? (PW'(0) - sum) : sum;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      negate  <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
    end else begin
      state   <= stateNext;
      mcand   <= mcandNext;
      mplier  <= mplierNext;
      acc     <= accNext;
      count   <= countNext;
      negate  <= negateNext;
      oBusy   <= busyNext;
      oDone   <= doneNext;
      oResult <= resultNext;
    end
  end

endmodule
